// File: rtl/score_pkg.sv
// score_pkg: shared definitions for the score display slice.
//   - seven-segment glyph constants (active high, bit0 = a ... bit6 = g)
//   - one-hot digit-select constants
//   - converter state enum
//   - MAX_SCORE, the largest value the two-digit display can show
//   - seg_decode(): BCD digit to glyph, blank for anything above 9
package score_pkg;

   localparam int MAX_SCORE = 99;

   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   localparam logic [1:0] DIG_ONES = 2'b01;
   localparam logic [1:0] DIG_TENS = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } conv_state_e;

   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/bin2bcd.sv
// bin2bcd: iterative double-dabble converter for a clamped 0..99 value.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   value_i         raw binary value (BW bits)
//   start_i         begin a conversion of clamped_o (only honoured in IDLE)
//   clamped_o       value_i limited to MAX_SCORE (combinational)
//   state_o         current converter state, for observation
//   busy_o          high in SHIFT and DONE (registered)
//   bcd_tens_o/bcd_ones_o  last completed conversion (registered)
// Handshake: start_i is a single-cycle request; it is accepted only when
// state_o is IDLE, and the result appears BW+1 edges after acceptance.
module bin2bcd
   import score_pkg::*;
#(
   parameter int BW = 7
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [BW-1:0] value_i,
   input  logic          start_i,
   output logic [BW-1:0] clamped_o,
   output conv_state_e   state_o,
   output logic          busy_o,
   output logic [3:0]    bcd_tens_o,
   output logic [3:0]    bcd_ones_o
);

   // Shift register layout: {tens nibble, ones nibble, binary}
   localparam int SW = BW + 8;
   localparam int CW = (BW > 1) ? $clog2(BW) : 1;

   conv_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [SW-1:0] sr_q, sr_d, sr_adj;
   logic [3:0]    tens_q, tens_d, ones_q, ones_d;
   logic          busy_q, busy_d;

   always_comb begin
      clamped_o = (value_i > BW'(MAX_SCORE)) ? BW'(MAX_SCORE) : value_i;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      busy_d  = busy_q;
      sr_adj  = sr_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               sr_d    = {8'd0, clamped_o};
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // Add-3 correction before the shift keeps each nibble decimal.
            if (sr_q[SW-1 -: 4] >= 4'd5) sr_adj[SW-1 -: 4] = sr_q[SW-1 -: 4] + 4'd3;
            if (sr_q[SW-5 -: 4] >= 4'd5) sr_adj[SW-5 -: 4] = sr_q[SW-5 -: 4] + 4'd3;
            sr_d  = {sr_adj[SW-2:0], 1'b0};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(BW - 1)) state_d = DONE;
         end
         DONE: begin
            tens_d  = sr_q[SW-1 -: 4];
            ones_d  = sr_q[SW-5 -: 4];
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         tens_q  <= 4'd0;
         ones_q  <= 4'd0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
         busy_q  <= busy_d;
      end
   end

   assign state_o    = state_q;
   assign busy_o     = busy_q;
   assign bcd_tens_o = tens_q;
   assign bcd_ones_o = ones_q;

endmodule

// File: rtl/score_display.sv
// score_display: two-digit multiplexed seven-segment display of a score.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks a zero tens digit.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   value_i            binary score (BW bits), values above 99 shown as 99
//   bcd_tens_o/ones_o  converted digits
//   busy_o             conversion in progress
//   digit_sel_o        one-hot digit enable (bit0 ones, bit1 tens)
//   seg_o              segments a..g, active high
module score_display
   import score_pkg::*;
#(
   parameter int BW          = 7,
   parameter int REFRESH_DIV = 16
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [BW-1:0] value_i,
   output logic [3:0]    bcd_tens_o,
   output logic [3:0]    bcd_ones_o,
   output logic          busy_o,
   output logic [1:0]    digit_sel_o,
   output logic [6:0]    seg_o
);

   localparam int RW = $clog2(REFRESH_DIV);

   logic [BW-1:0] last_q, last_d;
   logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
   logic [1:0]    digit_sel_q, digit_sel_d;
   logic [BW-1:0] clamped;
   conv_state_e   conv_state;
   logic          start;
   logic [3:0]    digit;

   bin2bcd #(.BW(BW)) u_bin2bcd (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .value_i    (value_i),
      .start_i    (start),
      .clamped_o  (clamped),
      .state_o    (conv_state),
      .busy_o     (busy_o),
      .bcd_tens_o (bcd_tens_o),
      .bcd_ones_o (bcd_ones_o)
   );

   // Compare against the clamped value so that inputs which clamp to the
   // same display value never trigger a pointless reconversion.
   always_comb begin
      start  = (conv_state == IDLE) && (clamped != last_q);
      last_d = start ? clamped : last_q;
   end

   always_comb begin
      refresh_cnt_d = refresh_cnt_q + RW'(1);
      digit_sel_d   = digit_sel_q;
      if (refresh_cnt_q == RW'(REFRESH_DIV - 1)) begin
         refresh_cnt_d = '0;
         digit_sel_d   = (digit_sel_q == DIG_ONES) ? DIG_TENS : DIG_ONES;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_q        <= '0;
         refresh_cnt_q <= '0;
         digit_sel_q   <= DIG_ONES;
      end else begin
         last_q        <= last_d;
         refresh_cnt_q <= refresh_cnt_d;
         digit_sel_q   <= digit_sel_d;
      end
   end

   // Decode only from registers so the segment bus never glitches.
   always_comb begin
      digit = (digit_sel_q == DIG_TENS) ? bcd_tens_o : bcd_ones_o;
      seg_o = seg_decode(digit);
`ifdef LEADING_ZERO_BLANK_EN
      if ((digit_sel_q == DIG_TENS) && (bcd_tens_o == 4'd0)) seg_o = SEG_BLANK;
`endif
   end

   assign digit_sel_o = digit_sel_q;

endmodule
